// File: rtl/ms_alarm_if.sv
// rtl/ms_alarm_if.sv - control/status bundle between software register slice and ms_alarm
interface ms_alarm_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ms_value;
  logic             start;
  logic [WIDTH-1:0] duration;
  logic             periodic;
  logic             cancel;
  logic             irq_clr;
  logic             busy;
  logic             done;
  logic             expired;
  logic             irq;
  logic             overrun;
  logic [WIDTH-1:0] remaining;

  modport slave (
    input  ms_value, start, duration, periodic, cancel, irq_clr,
    output busy, done, expired, irq, overrun, remaining
  );

  modport master (
    output ms_value, start, duration, periodic, cancel, irq_clr,
    input  busy, done, expired, irq, overrun, remaining
  );
endinterface

// File: rtl/ms_alarm.sv
// rtl/ms_alarm.sv - millisecond deadline alarm with one-shot/periodic modes, cancel and overrun
module ms_alarm #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        n_rst,
  ms_alarm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  // Largest positive signed interval keeps the MSB-of-difference compare unambiguous.
  localparam logic [WIDTH-1:0] MAX_DUR = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] deadline_q, deadline_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] dur_eff;
  logic [WIDTH-1:0] diff;
  logic             hit;
  logic             hit_taken;

  assign dur_eff = bus.duration[WIDTH-1] ? MAX_DUR : bus.duration;
  assign diff    = bus.ms_value - deadline_q;
  assign hit     = (state_q == ARMED) && !diff[WIDTH-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      deadline_q  <= '0;
      period_q    <= '0;
      remaining_q <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      expired_q   <= 1'b0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      deadline_q  <= deadline_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      expired_q   <= expired_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deadline_d = deadline_q;
    period_d   = period_q;
    mode_d     = mode_q;
    expired_d  = 1'b0;
    irq_d      = irq_q;
    overrun_d  = overrun_q;
    hit_taken  = 1'b0;

    if (bus.cancel) begin
      state_d = IDLE;
    end else if (bus.start) begin
      deadline_d = bus.ms_value + dur_eff;
      period_d   = dur_eff;
      mode_d     = bus.periodic;
      state_d    = ARMED;
    end else if (hit) begin
      hit_taken = 1'b1;
      expired_d = 1'b1;
      // Periodic deadlines advance from the previous deadline so late service never drifts.
      if (mode_q) begin
        deadline_d = deadline_q + period_q;
      end else begin
        state_d = FIRED;
      end
    end

    if (hit_taken) begin
      irq_d     = 1'b1;
      overrun_d = bus.irq_clr ? 1'b0 : (overrun_q | irq_q);
    end else if (bus.irq_clr) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end

    if ((state_q == ARMED) && !hit && !bus.cancel && !bus.start) begin
      remaining_d = deadline_q - bus.ms_value;
    end else begin
      remaining_d = '0;
    end

    busy_d = (state_d == ARMED);
    done_d = (state_d == FIRED);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.expired   = expired_q;
  assign bus.irq       = irq_q;
  assign bus.overrun   = overrun_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_ms_alarm.sv
// tb/tb_ms_alarm.sv - directed scoreboard bench for ms_alarm
module tb_ms_alarm;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];

  ms_alarm_if #(.WIDTH(32)) bus ();

  ms_alarm #(.WIDTH(32)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock; every expired pulse is matched against the ms_value sampled at the hit edge.
  task automatic tick();
    logic [31:0] sampled;
    logic [31:0] want;
    sampled = bus.ms_value;
    @(posedge clk);
    #1;
    if (bus.expired === 1'b1) begin
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("expiry_ms", sampled, want);
      end else begin
        check("spurious_expiry", {31'd0, bus.expired}, 32'd0);
      end
    end
  endtask

  task automatic step_ms(input logic [31:0] v);
    bus.ms_value = v;
    tick();
  endtask

  task automatic arm(input logic [31:0] ms, input logic [31:0] dur, input logic per);
    bus.ms_value = ms;
    bus.duration = dur;
    bus.periodic = per;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    n_rst        = 1'b0;
    bus.ms_value = '0;
    bus.start    = 1'b0;
    bus.duration = '0;
    bus.periodic = 1'b0;
    bus.cancel   = 1'b0;
    bus.irq_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    check("rst_busy",      {31'd0, bus.busy},    32'd0);
    check("rst_done",      {31'd0, bus.done},    32'd0);
    check("rst_expired",   {31'd0, bus.expired}, 32'd0);
    check("rst_irq",       {31'd0, bus.irq},     32'd0);
    check("rst_overrun",   {31'd0, bus.overrun}, 32'd0);
    check("rst_remaining", bus.remaining,        32'd0);

    // One-shot: 100 + 5
    exp_q.push_back(32'd105);
    arm(32'd100, 32'd5, 1'b0);
    check("os_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check("os_rem_5", bus.remaining, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      step_ms(32'd100 + k);
      check("os_rem", bus.remaining, 32'd5 - k);
    end
    check("os_done", {31'd0, bus.done}, 32'd1);
    check("os_busy_low", {31'd0, bus.busy}, 32'd0);
    check("os_irq", {31'd0, bus.irq}, 32'd1);
    step_ms(32'd106);
    step_ms(32'd107);
    check("os_pending", exp_q.size(), 32'd0);
    pulse_clr();
    check("clr_irq", {31'd0, bus.irq}, 32'd0);

    // Wrap-around: 0xFFFFFFFE + 4 -> 2
    exp_q.push_back(32'd2);
    arm(32'hFFFF_FFFE, 32'd4, 1'b0);
    step_ms(32'hFFFF_FFFF);
    step_ms(32'd0);
    step_ms(32'd1);
    check("wrap_rem_1", bus.remaining, 32'd1);
    step_ms(32'd2);
    check("wrap_done", {31'd0, bus.done}, 32'd1);
    check("wrap_pending", exp_q.size(), 32'd0);
    pulse_clr();

    // Periodic 3 from 10, with stall at 16 and a hold at 30
    exp_q.push_back(32'd13);
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd19);
    arm(32'd10, 32'd3, 1'b1);
    for (int m = 11; m <= 15; m++) step_ms(m);
    repeat (5) step_ms(32'd16);
    check("per_rem_stall", bus.remaining, 32'd3);
    step_ms(32'd17);
    step_ms(32'd18);
    step_ms(32'd19);
    check("per_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) exp_q.push_back(32'd30);
    repeat (5) step_ms(32'd30);
    check("per_hold_count", exp_q.size(), 32'd0);
    exp_q.push_back(32'd31);
    step_ms(32'd31);
    step_ms(32'd32);
    check("per_rem_after", bus.remaining, 32'd2);
    pulse_cancel();
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    check("cancel_rem", bus.remaining, 32'd0);
    check("cancel_keeps_irq", {31'd0, bus.irq}, 32'd1);
    pulse_clr();

    // Overrun: periodic 2 from 40
    exp_q.push_back(32'd42);
    exp_q.push_back(32'd44);
    exp_q.push_back(32'd46);
    arm(32'd40, 32'd2, 1'b1);
    step_ms(32'd41);
    step_ms(32'd42);
    check("ovr_irq1", {31'd0, bus.irq}, 32'd1);
    check("ovr_first", {31'd0, bus.overrun}, 32'd0);
    step_ms(32'd43);
    step_ms(32'd44);
    check("ovr_second", {31'd0, bus.overrun}, 32'd1);
    step_ms(32'd45);
    bus.irq_clr = 1'b1;
    step_ms(32'd46);
    bus.irq_clr = 1'b0;
    check("ovr_clr_irq", {31'd0, bus.irq}, 32'd1);
    check("ovr_clr_ovr", {31'd0, bus.overrun}, 32'd0);
    pulse_cancel();
    check("ovr_pending", exp_q.size(), 32'd0);
    pulse_clr();

    // Period 0 fires every cycle; cancel beats the hit
    repeat (3) exp_q.push_back(32'd80);
    arm(32'd80, 32'd0, 1'b1);
    repeat (3) tick();
    pulse_cancel();
    check("p0_overrun", {31'd0, bus.overrun}, 32'd1);
    check("p0_pending", exp_q.size(), 32'd0);
    pulse_clr();

    // start + cancel together
    bus.cancel = 1'b1;
    arm(32'd50, 32'd5, 1'b0);
    bus.cancel = 1'b0;
    check("sc_busy", {31'd0, bus.busy}, 32'd0);
    for (int m = 51; m <= 57; m++) step_ms(m);
    check("sc_done", {31'd0, bus.done}, 32'd0);

    // Restart with 1 ms left discards the old deadline
    arm(32'd60, 32'd3, 1'b0);
    step_ms(32'd61);
    step_ms(32'd62);
    check("rs_rem_1", bus.remaining, 32'd1);
    exp_q.push_back(32'd73);
    arm(32'd63, 32'd10, 1'b0);
    for (int m = 64; m <= 73; m++) step_ms(m);
    check("rs_done", {31'd0, bus.done}, 32'd1);
    check("rs_pending", exp_q.size(), 32'd0);

    // Asynchronous reset mid-ARMED
    arm(32'd100, 32'd10, 1'b0);
    step_ms(32'd101);
    check("ar_busy", {31'd0, bus.busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("ar_busy0", {31'd0, bus.busy}, 32'd0);
    check("ar_irq0", {31'd0, bus.irq}, 32'd0);
    check("ar_rem0", bus.remaining, 32'd0);
    check("ar_done0", {31'd0, bus.done}, 32'd0);
    bus.ms_value = 32'd120;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    check("ar_idle", {31'd0, bus.busy}, 32'd0);

    // Clamp of an oversized duration
    arm(32'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    check("clamp_rem", bus.remaining, 32'h7FFF_FFFF);
    pulse_cancel();
    check("final_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ms_alarm.md
# ms_alarm

Millisecond alarm that consumes the free-running 32-bit millisecond count produced by the AXI timer block and raises an event when a programmed duration has elapsed. Software, through the AXI register slice, loads a duration and starts it. The block computes an absolute deadline, compares it against the live millisecond count, and signals expiry with a one-cycle pulse and a sticky interrupt flag. It supports one-shot and drift-free periodic modes, cancel, and overrun detection.

## Interface
- WIDTH, 32: width of the millisecond count, duration and remaining-time paths
- clk  in  1  system clock (100 MHz)
- n_rst  in  1  asynchronous, active-low reset
- ms_value  in  WIDTH  free-running millisecond count from the timer; increments by 1 and wraps modulo 2^WIDTH
- start  in  1  single-cycle pulse: arm the alarm with `duration`
- duration  in  WIDTH  alarm interval in ms, sampled when `start` is high
- periodic  in  1  mode select, sampled when `start` is high: 0 = one-shot, 1 = periodic
- cancel  in  1  single-cycle pulse: disarm
- irq_clr  in  1  single-cycle pulse: clear `irq` and `overrun`
- busy  out  1  high while in ARMED
- done  out  1  high while in FIRED (one-shot completed)
- expired  out  1  one-cycle pulse per expiry
- irq  out  1  sticky expiry flag
- overrun  out  1  sticky flag: an expiry occurred while `irq` was already set
- remaining  out  WIDTH  ms left until the deadline; 0 when not armed

## Operation
- Internal registers:
  - deadline[WIDTH]
  - period[WIDTH]
  - mode
  - 2-bit state: IDLE, ARMED, FIRED
- Duration clamp: the effective duration `d` = min(duration, 2^(WIDTH-1)-1). This keeps the signed wrap-around compare valid.
- On start (from any state):
  - deadline <= ms_value + d (mod 2^WIDTH)
  - period <= d
  - mode <= periodic
  - state <= ARMED
- Hit condition, evaluated only in ARMED: MSB of (ms_value - deadline) == 0, i.e. signed difference ≥ 0. This is wrap-safe across the 0xFFFFFFFF→0 boundary.
- On a hit:
  - One-shot: state <= FIRED.
  - Periodic: deadline <= deadline + period. Stay in ARMED. The next deadline is computed from the old deadline, never from ms_value, so there is no drift.
  - In both modes: expired <= 1 for one cycle and irq <= 1.
  - overrun <= 1 if irq was already 1 and irq_clr is low at the same edge.
- Cancel: state <= IDLE from any state. No expiry is generated. irq and overrun are unchanged.
- FIRED → ARMED only on start. FIRED → IDLE on cancel.
- remaining (registered): deadline - ms_value while ARMED and not hit, else 0.
- Priority at a single edge:
  - cancel > start > hit.
  - start while ARMED restarts with the new duration; a hit in the same cycle is discarded.
  - An irq set from a hit beats irq_clr: irq stays 1 and overrun is cleared.
- Duration 0: the hit is true in the first ARMED cycle. In periodic mode with period 0, an expiry fires every cycle; this is legal and is reported through overrun.

## Timing
- Reset (n_rst low, asynchronous): state IDLE; deadline, period, mode and remaining cleared; busy, done, expired, irq, overrun all 0. Reset asserted mid-ARMED aborts the alarm with no expired pulse. Outputs are valid from the first edge after release.
- start sampled at edge N:
  - busy = 1 from cycle N+1.
  - remaining valid from N+2 (one register stage).
- Hit true at edge K:
  - expired = 1 during cycle K+1 only.
  - irq = 1 from K+1.
  - done = 1 from K+1 (one-shot).
  - Latency from ms_value reaching the deadline to the expired pulse: 1 cycle.
- irq_clr sampled at edge M: irq and overrun are 0 from M+1, unless a hit occurs at M.
- cancel sampled at edge M: busy = 0 and remaining = 0 from M+1.
- All outputs are registered. No combinational path runs from an input to an output.

## Test plan
- One-shot, ms_value = 100, start with duration = 5:
  - expired pulses once, in the cycle after ms_value = 105 is sampled.
  - done = 1, busy = 0, irq = 1.
  - remaining counts 5,4,…,1,0.
- Wrap-around: ms_value = 0xFFFF_FFFE, duration = 4:
  - deadline = 0x0000_0002.
  - No expiry at 0xFFFF_FFFF, 0 or 1; expiry when ms_value = 2 is sampled.
- Periodic, duration = 3 from ms_value = 10:
  - expiries at 13, 16, 19.
  - Stalling ms_value for 5 cycles at 16 yields exactly one pulse at 16.
  - Holding ms_value at 30 for several cycles (no increments) yields one pulse per cycle until deadline > 30; the deadline then resumes at 31, with no drift.
- Overrun: periodic duration = 2, irq not cleared:
  - overrun = 1 after the 2nd expiry.
  - irq_clr coinciding with the 3rd expiry leaves irq = 1 and overrun = 0.
- Simultaneous controls:
  - start + cancel at the same edge → IDLE, busy = 0.
  - start while ARMED with 1 ms left, duration = 10 → no expiry at the old deadline; expiry 10 ms later.
- Reset and clamp:
  - n_rst pulsed low mid-ARMED → all outputs 0 immediately, no expired pulse.
  - duration = 0xFFFF_FFFF → clamped to 0x7FFF_FFFF (remaining = 0x7FFF_FFFF two cycles after start).
